// File: rtl/tag_pkg.sv
// Shared types and sizing helpers for the tag resolver slice.
package tag_pkg;

  localparam int unsigned WORDS_DEF = 100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENUM = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Index width that stays at least one bit for a single-word array.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/tag_prio_enc.sv
// Lowest-index priority encoder: word 0 wins; index is 0 when no bit is set.
module tag_prio_enc #(
  parameter int unsigned WORDS = 100,
  parameter int unsigned IDX_W = 7
) (
  input  logic [WORDS-1:0] vec,
  output logic             any,
  output logic [WORDS-1:0] onehot,
  output logic [IDX_W-1:0] index
);

  assign any    = |vec;
  // Two's-complement trick isolates the lowest set bit.
  assign onehot = vec & (~vec + WORDS'(1));

  always_comb begin
    index = '0;
    for (int i = int'(WORDS) - 1; i >= 0; i--) begin
      if (vec[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tag_resolver.sv
// Tag register plus multiple-response resolver and responder enumerator.
// Optional handshake counter output enabled by TAG_RESOLVER_COUNT_EN.
module tag_resolver
  import tag_pkg::*;
#(
  parameter int unsigned WORDS = WORDS_DEF,
  parameter int unsigned IDX_W = idx_width(WORDS)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WORDS-1:0] match_lines,
  input  logic             set,
  input  logic             load,
  input  logic             select_first,
  input  logic             enum_start,
  input  logic             resp_ready,
  output logic [WORDS-1:0] tag_wires,
`ifdef TAG_RESOLVER_COUNT_EN
  output logic [cnt_width(WORDS)-1:0] resp_count,
`endif
  output logic             some_tag,
  output logic             resp_valid,
  output logic [IDX_W-1:0] resp_index,
  output logic             enum_done,
  output logic             busy
);

  localparam int unsigned CNT_W = cnt_width(WORDS);

  state_e           state_q, state_d;
  logic [WORDS-1:0] tags_q, tags_d;
  logic             enc_any;
  logic [WORDS-1:0] enc_onehot;
  logic [IDX_W-1:0] enc_index;
  logic [WORDS-1:0] tags_cleared;
  logic             handshake;

`ifdef TAG_RESOLVER_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;
`endif

  tag_prio_enc #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec    (tags_q),
    .any    (enc_any),
    .onehot (enc_onehot),
    .index  (enc_index)
  );

  assign tags_cleared = tags_q & ~enc_onehot;
  assign handshake    = resp_valid & resp_ready;

  assign tag_wires  = tags_q;
  assign some_tag   = enc_any;
  assign resp_index = enc_index;
  assign resp_valid = (state_q == S_ENUM) & enc_any;
  assign enum_done  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
`ifdef TAG_RESOLVER_COUNT_EN
  assign resp_count = count_q;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      tags_q  <= '0;
`ifdef TAG_RESOLVER_COUNT_EN
      count_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tags_q  <= tags_d;
`ifdef TAG_RESOLVER_COUNT_EN
      count_q <= count_d;
`endif
    end
  end

  // Commands act only in IDLE; ENUM retires one responder per handshake.
  always_comb begin
    state_d = state_q;
    tags_d  = tags_q;
`ifdef TAG_RESOLVER_COUNT_EN
    count_d = count_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (set) begin
          tags_d = '1;
        end else if (load) begin
          tags_d = tags_q & match_lines;
        end else if (select_first) begin
          tags_d = enc_onehot;
        end else if (enum_start) begin
          state_d = S_ENUM;
`ifdef TAG_RESOLVER_COUNT_EN
          count_d = '0;
`endif
        end
      end
      S_ENUM: begin
        if (!enc_any) begin
          state_d = S_DONE;
        end else if (handshake) begin
          tags_d = tags_cleared;
`ifdef TAG_RESOLVER_COUNT_EN
          if (count_q != CNT_W'(WORDS)) count_d = count_q + CNT_W'(1);
`endif
          if (tags_cleared == '0) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/tag_resolver.md
Name: tag_resolver

Overview:
- Tag register and multiple-response resolver downstream of the cell array; consumes the per-word match_lines produced by a masked search.
- Holds one tag bit per word, ANDs search results into it, and reduces it to a single responder (select-first) for the read/write stages.
- Also enumerates all responders one at a time over a valid/ready handshake.
- Its tag_wires output drives word selection for the next write or read cycle.

Parameters:
- WORDS, 100, number of CAPP words (width of match_lines and tag_wires).
- IDX_W, $clog2(WORDS), width of the responder index.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RST_N  input  1  synchronous active-low reset.
- match_lines  input  WORDS  per-word match result from the cell array, 1 = word matched.
- set  input  1  command: set every tag bit to 1.
- load  input  1  command: tags <= tags & match_lines.
- select_first  input  1  command: keep only the lowest-index set tag.
- enum_start  input  1  begin responder enumeration.
- resp_ready  input  1  consumer accepts the current responder.
- tag_wires  output  WORDS  registered tag bits.
- some_tag  output  1  OR of tag_wires.
- resp_valid  output  1  a responder is presented (ENUM state only).
- resp_index  output  IDX_W  index of the lowest set tag; 0 when none.
- enum_done  output  1  one-cycle pulse when enumeration finishes.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (RST_N low at a CLK edge): tag_wires = 0, state = IDLE, enum_done = 0. All outputs derived from these values: some_tag = 0, resp_valid = 0, resp_index = 0, busy = 0.
- Reset mid-enumeration aborts immediately. No enum_done pulse is produced.
- FSM states: IDLE, ENUM, DONE.
- IDLE commands, one per cycle, priority set > load > select_first > enum_start. Lower-priority commands asserted in the same cycle are dropped.
  - set: tags = all 1s, next cycle.
  - load: tags = tags & match_lines.
  - select_first: tags = onehot(lowest set tag); no change if tags = 0.
  - enum_start: go to ENUM.
- ENUM:
  - resp_valid = some_tag.
  - On resp_valid & resp_ready: clear the bit at resp_index.
  - If that cleared the last bit, or tags are already 0 on entry, go to DONE.
  - set, load and select_first are ignored; busy = 1.
- DONE: enum_done = 1 for exactly one cycle, then return to IDLE.
- Combinational outputs: resp_index and some_tag come from the current tag register with zero latency. Command effects appear on tag_wires one cycle after the command edge.
- resp_index is the lowest set bit (word 0 has highest priority). resp_index changes only after a handshake.
- resp_ready while resp_valid = 0 has no effect.
- enum_start in ENUM or DONE is ignored.

Optional Feature:
- Macro TAG_RESOLVER_COUNT_EN.
- Defined: extra output resp_count, width $clog2(WORDS+1), holding the number of handshakes in the current enumeration.
  - Cleared on reset and on entry to ENUM.
  - Incremented per accepted responder.
  - Saturates at WORDS.
  - Holds its value through DONE and IDLE.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tag_pkg: FSM state enum (IDLE/ENUM/DONE), default WORDS constant, index-width helper.
- One sub-module, tag_prio_enc: combinational lowest-index priority encoder with outputs any, onehot[WORDS] and index[IDX_W]. It is used for both select_first and resp_index.

Test Plan:
- Reset, then set, then load with match_lines bits 3, 7 and 99 set → tag_wires has only bits 3, 7, 99; some_tag = 1; resp_index = 3.
- From that state, select_first → tag_wires = 1<<3 next cycle; a second select_first leaves it unchanged.
- From tags {3, 7, 99}, enum_start with resp_ready tied 1 → resp_index 3, 7, 99 on consecutive cycles, then enum_done one cycle; with COUNT_EN, resp_count = 3.
- ENUM with resp_ready toggling 1/0 and load asserted throughout → load ignored; each index held until accepted; busy = 1 until IDLE.
- enum_start with tags = 0 → resp_valid never asserts; DONE with enum_done pulse, then IDLE.
- set and load in the same cycle → all 1s (set wins). RST_N low during ENUM → next cycle IDLE, tags 0, no enum_done.
